demux4_reg: RTL and testbench
=============================

# demux4_reg

Registered 1-to-4 demultiplexer with valid/ready handshakes: the steering counterpart to the `mux4` selector. It takes a single producer stream and, per beat, routes the data word to one of four consumer channels chosen by a 2-bit select. Each channel has a one-entry output register, so a stalled consumer blocks only beats addressed to it. It sits between a shared result/issue bus and per-unit queues in the datapath.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: producer has a beat on `in_data`/`in_sel`.
- `in_ready` output 1: demux accepts the beat this cycle (combinational).
- `in_data` input WIDTH: producer data word.
- `in_sel` input 2: destination channel 0..3; meaningful only while `in_valid`=1.
- `out_valid` output 4: bit k = channel k holds a beat.
- `out_ready` input 4: bit k = consumer k takes the beat this cycle.
- `out_data0`..`out_data3` output WIDTH each: channel k holding register.
- `xfer_cnt` output 8: count of accepted input beats, wraps modulo 256.

## Operation
- Per channel k: state EMPTY (`out_valid[k]`=0) or FULL (`out_valid[k]`=1).
- `in_ready` = `~out_valid[in_sel] | out_ready[in_sel]`; it depends on `in_sel` and `out_ready`, but not on `in_valid`.
- Accept = `in_valid & in_ready`. On accept: `out_dataS` <= `in_data`, `out_valid[S]` <= 1 (S = `in_sel`), `xfer_cnt` <= `xfer_cnt`+1.
- Drain on channel k = `out_valid[k] & out_ready[k]`. If it coincides with no accept to k, `out_valid[k]` <= 0.
- Drain and accept on the same channel in the same cycle: `out_valid[k]` stays 1 and `out_dataK` takes the new word. Full throughput of 1 beat/cycle per channel.
- Channels are independent: a drain on j and an accept on k≠j in the same cycle both take effect.
- `out_dataK` is loaded only on accept to k. It holds its last value after a drain, and it is don't-care while `out_valid[k]`=0.
- `out_ready[k]` while `out_valid[k]`=0 has no effect.
- Producer rule: while `in_valid`=1 and `in_ready`=0, hold `in_data`/`in_sel` stable. The demux does not store un-accepted beats.
- `xfer_cnt` width arithmetic: 8-bit unsigned, 255+1 -> 0, no saturation.

## Timing
- Reset (asynchronous, immediate): `out_valid`=4'b0000, `out_data0..3`=0, `xfer_cnt`=0. Any pending beats are discarded. With every channel then EMPTY, `in_ready`=1 while `rst` is asserted (combinational), but no beat is accepted until `rst` deasserts.
- Latency: a beat accepted at edge n is visible on `out_valid[S]`/`out_dataS` after edge n.
- Back-pressure: channel k FULL with `out_ready[k]`=0 -> `in_ready`=0 for every beat selecting k. Beats selecting other channels are unaffected.
- No combinational path from `in_valid`/`in_data` to any output. The only combinational path is `in_sel`/`out_ready` -> `in_ready`.

## Test plan
- Reset: hold `rst`=1 mid-traffic with channel 2 FULL -> `out_valid`=0000, `xfer_cnt`=0 before the next edge; `in_ready`=1 after release.
- Steering: with all `out_ready`=1, send 0xA0,0xA1,0xA2,0xA3 with `in_sel`=0,1,2,3 on consecutive cycles -> each appears on `out_dataK` one cycle later with single-cycle `out_valid[K]` pulses, and `xfer_cnt`=4.
- Stall isolation: `out_ready[1]`=0, fill channel 1 with 0x11, then offer 0x22 (sel 1) -> `in_ready`=0 and `out_data1` stays 0x11. Switch to 0x33 (sel 3) -> accepted next cycle. Raise `out_ready[1]` -> 0x22 accepted.
- Drain+refill: channel 0 FULL with 0x55, `out_ready[0]`=1, offer 0x66 sel 0 in the same cycle -> `in_ready`=1 and `out_valid[0]` stays 1 with `out_data0`=0x66. Sustain this for 8 cycles -> 8 beats delivered with no bubbles.
- Counter wrap: accept 257 beats -> `xfer_cnt`=1.
- Held beat: `in_valid`=1 while stalled for 5 cycles, then `out_ready` is asserted -> exactly one copy is delivered, and `xfer_cnt` increments by 1.

Source files
------------

// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes.
// A single producer stream is steered, beat by beat, into one of four
// one-entry output registers selected by in_sel. Each channel stalls only
// the beats addressed to it, and a full channel can drain and refill in
// the same cycle for one beat per cycle per channel.
module demux4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [7:0]       xfer_cnt
);

    // Channel select to one-hot destination mask.
    function automatic logic [3:0] sel_to_onehot(input logic [1:0] sel);
        logic [3:0] mask;
        case (sel)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic [7:0]       r_cnt;

    logic [3:0]       w_sel_mask;
    logic [3:0]       w_chan_ready;
    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_drain;
    logic [3:0]       w_valid_nxt;

    // Handshake decode: a channel can take a beat when it is empty or is
    // being drained this cycle; in_ready depends only on in_sel/out_ready.
    always_comb begin
        w_sel_mask   = sel_to_onehot(in_sel);
        w_chan_ready = ~r_valid | out_ready;
        w_in_ready   = |(w_sel_mask & w_chan_ready);
        w_accept     = in_valid & w_in_ready;
        if (w_accept) begin
            w_load = w_sel_mask;
        end else begin
            w_load = 4'b0000;
        end
        w_drain     = r_valid & out_ready;
        // A load wins over a drain on the same channel, keeping it full.
        w_valid_nxt = w_load | (r_valid & ~w_drain);
    end

    // Channel occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'b0000;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Channel holding registers: loaded only on an accepted beat to that
    // channel, otherwise they keep their last word (also after a drain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end else begin
                    r_data[k] <= r_data[k];
                end
            end
        end
    end

    // Accepted-beat counter, wraps modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed testbench for demux4_reg with hand-computed expectations.
module tb_demux4_reg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [7:0] xfer_cnt;

    int chk_cnt = 0;
    int err_cnt = 0;

    demux4_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, settling 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and let in_ready settle.
    task automatic offer(input logic v, input logic [1:0] s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'b0000;

        // ---------------- power-on reset ----------------
        tick();
        tick();
        check_eq("por_valid", {28'd0, out_valid}, 32'h0);
        check_eq("por_cnt", {24'd0, xfer_cnt}, 32'h0);
        check_eq("por_data2", {24'd0, out_data2}, 32'h0);
        check_eq("por_ready", {31'd0, in_ready}, 32'h1);
        rst = 1'b0;
        #1;

        // ---------------- steering ----------------
        out_ready = 4'b1111;
        offer(1'b1, 2'd0, 8'hA0);
        check_eq("steer_rdy0", {31'd0, in_ready}, 32'h1);
        tick();
        check_eq("steer_v0", {28'd0, out_valid}, 32'h1);
        check_eq("steer_d0", {24'd0, out_data0}, 32'hA0);
        offer(1'b1, 2'd1, 8'hA1);
        tick();
        check_eq("steer_v1", {28'd0, out_valid}, 32'h2);
        check_eq("steer_d1", {24'd0, out_data1}, 32'hA1);
        offer(1'b1, 2'd2, 8'hA2);
        tick();
        check_eq("steer_v2", {28'd0, out_valid}, 32'h4);
        check_eq("steer_d2", {24'd0, out_data2}, 32'hA2);
        offer(1'b1, 2'd3, 8'hA3);
        tick();
        check_eq("steer_v3", {28'd0, out_valid}, 32'h8);
        check_eq("steer_d3", {24'd0, out_data3}, 32'hA3);
        check_eq("steer_cnt", {24'd0, xfer_cnt}, 32'd4);
        offer(1'b0, 2'd0, 8'h00);
        tick();
        check_eq("steer_idle", {28'd0, out_valid}, 32'h0);
        check_eq("steer_d0_hold", {24'd0, out_data0}, 32'hA0);

        // ---------------- stall isolation ----------------
        out_ready = 4'b1101;
        offer(1'b1, 2'd1, 8'h11);
        tick();
        check_eq("stall_v_fill", {28'd0, out_valid}, 32'h2);
        check_eq("stall_d1_fill", {24'd0, out_data1}, 32'h11);
        offer(1'b1, 2'd1, 8'h22);
        check_eq("stall_rdy_blocked", {31'd0, in_ready}, 32'h0);
        tick();
        check_eq("stall_d1_kept", {24'd0, out_data1}, 32'h11);
        check_eq("stall_cnt_kept", {24'd0, xfer_cnt}, 32'd5);
        offer(1'b1, 2'd3, 8'h33);
        check_eq("stall_rdy_other", {31'd0, in_ready}, 32'h1);
        tick();
        check_eq("stall_v_other", {28'd0, out_valid}, 32'hA);
        check_eq("stall_d3", {24'd0, out_data3}, 32'h33);
        out_ready = 4'b1111;
        offer(1'b1, 2'd1, 8'h22);
        check_eq("stall_rdy_release", {31'd0, in_ready}, 32'h1);
        tick();
        check_eq("stall_v_release", {28'd0, out_valid}, 32'h2);
        check_eq("stall_d1_new", {24'd0, out_data1}, 32'h22);
        check_eq("stall_cnt", {24'd0, xfer_cnt}, 32'd7);
        offer(1'b0, 2'd0, 8'h00);
        tick();
        check_eq("stall_idle", {28'd0, out_valid}, 32'h0);

        // ---------------- drain + refill ----------------
        offer(1'b1, 2'd0, 8'h55);
        tick();
        check_eq("dr_fill_d0", {24'd0, out_data0}, 32'h55);
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 2'd0, 8'h66 + 8'(i));
            check_eq("dr_rdy", {31'd0, in_ready}, 32'h1);
            tick();
            check_eq("dr_v", {28'd0, out_valid}, 32'h1);
            check_eq("dr_d0", {24'd0, out_data0}, 32'h66 + i);
        end
        check_eq("dr_cnt", {24'd0, xfer_cnt}, 32'd16);
        offer(1'b0, 2'd0, 8'h00);
        tick();
        check_eq("dr_idle", {28'd0, out_valid}, 32'h0);

        // ---------------- held beat ----------------
        out_ready = 4'b0000;
        offer(1'b1, 2'd2, 8'h77);
        tick();
        check_eq("hold_fill", {28'd0, out_valid}, 32'h4);
        offer(1'b1, 2'd2, 8'h88);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_rdy", {31'd0, in_ready}, 32'h0);
            tick();
            check_eq("hold_d2", {24'd0, out_data2}, 32'h77);
        end
        check_eq("hold_cnt_stalled", {24'd0, xfer_cnt}, 32'd17);
        out_ready = 4'b0100;
        #1;
        check_eq("hold_rdy_go", {31'd0, in_ready}, 32'h1);
        tick();
        check_eq("hold_d2_new", {24'd0, out_data2}, 32'h88);
        check_eq("hold_v", {28'd0, out_valid}, 32'h4);
        offer(1'b0, 2'd0, 8'h00);
        tick();
        check_eq("hold_idle", {28'd0, out_valid}, 32'h0);
        check_eq("hold_cnt_once", {24'd0, xfer_cnt}, 32'd18);

        // ---------------- reset mid-traffic ----------------
        out_ready = 4'b0000;
        offer(1'b1, 2'd2, 8'h99);
        tick();
        check_eq("rst_pre_v", {28'd0, out_valid}, 32'h4);
        offer(1'b1, 2'd0, 8'h5A);
        rst = 1'b1;
        #1;
        check_eq("rst_async_v", {28'd0, out_valid}, 32'h0);
        check_eq("rst_async_cnt", {24'd0, xfer_cnt}, 32'h0);
        check_eq("rst_async_d2", {24'd0, out_data2}, 32'h0);
        check_eq("rst_rdy", {31'd0, in_ready}, 32'h1);
        tick();
        check_eq("rst_no_accept_v", {28'd0, out_valid}, 32'h0);
        check_eq("rst_no_accept_cnt", {24'd0, xfer_cnt}, 32'h0);
        offer(1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        #1;
        check_eq("rst_rdy_after", {31'd0, in_ready}, 32'h1);

        // ---------------- counter wrap ----------------
        out_ready = 4'b1111;
        for (int i = 0; i < 257; i++) begin
            offer(1'b1, 2'(i % 4), 8'(i));
            tick();
            if (i == 255) begin
                check_eq("wrap_256", {24'd0, xfer_cnt}, 32'd0);
            end
        end
        check_eq("wrap_257", {24'd0, xfer_cnt}, 32'd1);
        check_eq("wrap_last_d0", {24'd0, out_data0}, 32'h00);
        offer(1'b0, 2'd0, 8'h00);
        tick();
        check_eq("wrap_idle_cnt", {24'd0, xfer_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule
